// File: rtl/operand_bypass_unit.sv
// Decode-stage operand resolution: picks the youngest in-flight write over the
// regfile value per source port, and raises a same-cycle interlock when that write is not ready.
module operand_bypass_lane #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_FWD = 3
) (
   input  logic                      rd_en_i,
   input  logic [ADDR_W-1:0]         rd_addr_i,
   input  logic [DATA_W-1:0]         rf_data_i,
   input  logic [NUM_FWD-1:0]        fwd_wreg_i,
   input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
   input  logic [NUM_FWD-1:0]        fwd_rdy_i,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
   output logic [DATA_W-1:0]         opnd_o,
   output logic                      blocked_o
);
   logic [NUM_FWD-1:0] w_hit;

   for (genvar t = 0; t < NUM_FWD; t++) begin : g_hit
      assign w_hit[t] = fwd_wreg_i[t]
                     && (fwd_wd_i[t*ADDR_W +: ADDR_W] == rd_addr_i)
                     && (fwd_wd_i[t*ADDR_W +: ADDR_W] != '0);
   end

   // Scan oldest to youngest so the lowest-index hit is the last one written;
   // its readiness alone decides blocking, older ready taps cannot mask it.
   always_comb begin
      opnd_o    = rf_data_i;
      blocked_o = 1'b0;
      if (!rd_en_i || rd_addr_i == '0) begin
         opnd_o = '0;
      end else begin
         for (int t = NUM_FWD-1; t >= 0; t--) begin
            if (w_hit[t]) begin
               opnd_o    = fwd_wdata_i[t*DATA_W +: DATA_W];
               blocked_o = !fwd_rdy_i[t];
            end
         end
      end
   end
endmodule

module operand_bypass_unit #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int NUM_RD    = 2,
   parameter int NUM_FWD   = 3,
   parameter int MAX_STALL = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid_i,
   input  logic                      flush_i,
   input  logic [NUM_RD-1:0]         rd_en_i,
   input  logic [NUM_RD*ADDR_W-1:0]  rd_addr_i,
   input  logic [NUM_RD*DATA_W-1:0]  rf_data_i,
   input  logic [NUM_FWD-1:0]        fwd_wreg_i,
   input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
   input  logic [NUM_FWD-1:0]        fwd_rdy_i,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
   output logic [NUM_RD*DATA_W-1:0]  opnd_o,
   output logic                      stallreq_o,
   output logic                      resolved_o,
   output logic                      stall_err_o,
   output logic [31:0]               stall_cycles_o
);
   localparam int CNT_W = $clog2(MAX_STALL + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

   typedef enum logic {S_IDLE, S_STALL} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_run_cnt;
   logic              r_resolved;
   logic              r_err;
   logic [31:0]       r_stall_cycles;

   logic [NUM_RD-1:0] w_blocked;
   logic              w_need_stall;
   logic [CNT_W-1:0]  w_run_nxt;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_lane
      operand_bypass_lane #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_FWD(NUM_FWD)
      ) u_lane (
         .rd_en_i    (rd_en_i[p]),
         .rd_addr_i  (rd_addr_i[p*ADDR_W +: ADDR_W]),
         .rf_data_i  (rf_data_i[p*DATA_W +: DATA_W]),
         .fwd_wreg_i (fwd_wreg_i),
         .fwd_wd_i   (fwd_wd_i),
         .fwd_rdy_i  (fwd_rdy_i),
         .fwd_wdata_i(fwd_wdata_i),
         .opnd_o     (opnd_o[p*DATA_W +: DATA_W]),
         .blocked_o  (w_blocked[p])
      );
   end

   // Flush dominates: a squashed instruction never stalls or advances counters.
   assign w_need_stall = id_valid_i && !flush_i && (|w_blocked);
   assign stallreq_o   = w_need_stall;
   assign w_run_nxt    = (r_run_cnt == MAX_CNT) ? MAX_CNT : r_run_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_run_cnt      <= '0;
         r_resolved     <= 1'b0;
         r_err          <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         r_state    <= w_need_stall ? S_STALL : S_IDLE;
         r_resolved <= (r_state == S_STALL) && !w_need_stall && !flush_i;
         if (w_need_stall) begin
            r_run_cnt <= w_run_nxt;
            if (w_run_nxt == MAX_CNT) r_err <= 1'b1;
            if (r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
         end else begin
            r_run_cnt <= '0;
         end
      end
   end

   assign resolved_o     = r_resolved;
   assign stall_err_o    = r_err;
   assign stall_cycles_o = r_stall_cycles;
endmodule

// File: doc/operand_bypass_unit.md
# operand_bypass_unit

Parametrised operand-resolution and interlock unit for the decode stage. For each source operand it selects the youngest in-flight write to the same register over the register-file value. When that producer's data is not yet available, such as a load still in EX, it raises a same-cycle stall and tracks the stall episode. It sits between regfile, the EX/MEM/WB result taps and the decode logic, replacing per-operand hard-coded forwarding.

## Interface
- `DATA_W`, 32: operand width.
- `ADDR_W`, 5: register-number width; register 0 is hard-wired zero.
- `NUM_RD`, 2: number of source operand ports.
- `NUM_FWD`, 3: number of forwarding taps; index 0 is youngest (EX), then MEM, then WB.
- `MAX_STALL`, 8: consecutive stall-cycle limit before the error flag sets (≥1).

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `id_valid_i` in 1: decode holds a real instruction.
- `flush_i` in 1: squash the decode instruction (branch or exception).
- `rd_en_i` in NUM_RD: per-port read enable.
- `rd_addr_i` in NUM_RD*ADDR_W: per-port register number, port p at [p*ADDR_W +: ADDR_W].
- `rf_data_i` in NUM_RD*DATA_W: regfile read data per port.
- `fwd_wreg_i` in NUM_FWD: tap writes a register.
- `fwd_wd_i` in NUM_FWD*ADDR_W: tap destination register.
- `fwd_rdy_i` in NUM_FWD: tap data is valid this cycle (0 for a load in EX).
- `fwd_wdata_i` in NUM_FWD*DATA_W: tap result.
- `opnd_o` out NUM_RD*DATA_W: resolved operand per port.
- `stallreq_o` out 1: hold PC and IF/ID this cycle.
- `resolved_o` out 1: registered one-cycle pulse when a stall episode ends without flush.
- `stall_err_o` out 1: sticky; stall episode exceeded MAX_STALL.
- `stall_cycles_o` out 32: saturating count of all cycles in STALL.

## Operation
- Per port p (combinational):
  - rd_en=0 or addr=0 -> operand 0.
  - Otherwise the hit on tap t requires fwd_wreg[t]=1 and fwd_wd[t]=addr.
  - The lowest-index hitting tap wins. Its data is used if fwd_rdy[t]=1; if fwd_rdy[t]=0, the port is blocked.
  - No hit -> rf_data.
  - An older ready tap never overrides a younger non-ready hit.
- need_stall = id_valid & ~flush & (any port blocked). stallreq_o = need_stall, same cycle, combinational.
- FSM states IDLE, STALL:
  - IDLE -> STALL when need_stall.
  - STALL stays while need_stall.
  - STALL -> IDLE when ~need_stall. resolved_o=1 the next cycle unless flush_i was high on the exiting cycle.
  - flush_i in any state -> IDLE next edge, no resolved pulse.
- Episode counter `run_cnt`:
  - Reset to 0 entering STALL.
  - Increments per STALL cycle, saturating at MAX_STALL.
  - When it reaches MAX_STALL while still stalling, stall_err_o sets. It clears only on reset.
- stall_cycles_o increments every cycle need_stall=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Operand and stall paths have zero latency: combinational from inputs within the cycle.
- resolved_o, stall_err_o and stall_cycles_o are registered and reflect the previous edge.
- Reset values: FSM IDLE, run_cnt 0, resolved_o 0, stall_err_o 0, stall_cycles_o 0. opnd_o and stallreq_o follow inputs, so they are 0 with all-zero inputs.
- Reset asserted mid-stall returns the block to IDLE immediately; no resolved pulse after release.
- Simultaneous flush_i and need_stall: flush wins. stallreq_o=0 and the counters do not advance.
- Two ports hitting the same tap both receive that tap's data. Either port blocked stalls the whole instruction.
- A tap with fwd_wd=0 is never matched.

## Test plan
- Default config, port0 reads r5:
  - EX tap writes r5=0x11 and MEM tap writes r5=0x22, both ready -> opnd0=0x11, no stall.
  - Same, with the EX tap removed -> opnd0=0x22.
- Load-use: EX tap r7 with rdy=0 for 1 cycle, then that producer reaches MEM with rdy=1 and data 0x33 -> stallreq high for 1 cycle, opnd0=0x33 next, resolved_o pulses 1 cycle later, stall_cycles_o=1.
- Register 0: read r0 with all taps targeting r0, data 0xFFFF_FFFF and rdy=0 -> opnd=0, stallreq=0.
- Timeout: non-ready EX hit held 9 cycles with MAX_STALL=8 -> stall_err_o set after the 8th stall cycle and stays 1 after the hazard clears; stall_cycles_o=9.
- Flush mid-stall: stall 2 cycles, then flush_i=1 -> stallreq=0 that cycle, FSM IDLE, resolved_o stays 0.
- Reset mid-stall: drop rst during STALL -> all registered outputs 0 immediately. After release with no hazard, no resolved pulse.
